force_reset_sequencer: RTL and testbench

FORCE_RESET_SEQUENCER -- requirements
Module: force_reset_sequencer

---
 rtl/force_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_force_reset_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/force_reset_sequencer.sv
// -----------------------------------------------------------------------------
// force_reset_sequencer
//
// Turns a level reset request (from the trigger monitor or from software)
// into a stretched, registered reset pulse. A cooldown window follows each
// pulse. Requests that arrive while a pulse or cooldown is in progress are
// ignored, and their rising edges are counted as drops.
//
// Parameters
//   STRETCH_CYCLES  : cycles rst_out stays high per accepted request (1..255)
//   COOLDOWN_CYCLES : blocking cycles after rst_out falls (0..255)
//   CNT_WIDTH       : width of event_count / drop_count
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, overrides every other input
//   force_reset  : level request from the trigger monitor
//   ext_rst_req  : level request from software/debug
//   clear_counts : synchronous clear of both counters (FSM unaffected)
//   rst_out      : stretched reset to the protected logic (registered)
//   busy         : high while the sequencer is not idle (registered)
//   req_ack      : one-cycle pulse marking an accepted request (registered)
//   event_count  : accepted requests, saturating
//   drop_count   : request rising edges rejected while busy, saturating
// -----------------------------------------------------------------------------
module force_reset_sequencer #(
  parameter int STRETCH_CYCLES  = 16,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 force_reset,
  input  logic                 ext_rst_req,
  input  logic                 clear_counts,
  output logic                 rst_out,
  output logic                 busy,
  output logic                 req_ack,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  // Timer must hold the larger of the two phase lengths.
  localparam int MAX_T = (STRETCH_CYCLES > COOLDOWN_CYCLES) ? STRETCH_CYCLES
                                                            : COOLDOWN_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] STRETCH_LOAD  = TW'(STRETCH_CYCLES - 1);
  // Only used when COOLDOWN_CYCLES > 0.
  localparam logic [TW-1:0] COOLDOWN_LOAD = TW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic            req, req_d, req_rise;
  logic            accept, drop;
  logic [CNT_WIDTH-1:0] event_n, drop_n;

  // Both sources merge into one request, so simultaneous assertion counts once.
  assign req      = force_reset | ext_rst_req;
  assign req_rise = req & ~req_d;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        // Level-based acceptance: a held request re-triggers after cooldown.
        if (req) begin
          state_n = ASSERT;
          timer_n = STRETCH_LOAD;
          accept  = 1'b1;
        end
      end
      ASSERT: begin
        if (timer_q == '0) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_n = IDLE;
            timer_n = '0;
          end else begin
            state_n = COOLDOWN;
            timer_n = COOLDOWN_LOAD;
          end
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      COOLDOWN: begin
        if (timer_q == '0) begin
          state_n = IDLE;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // A fresh edge while busy is recorded but never disturbs the sequence.
  assign drop = req_rise && (state_q != IDLE);

  // Clear beats a simultaneous increment; both counters stick at all-ones.
  always_comb begin
    event_n = event_count;
    drop_n  = drop_count;
    if (clear_counts) begin
      event_n = '0;
      drop_n  = '0;
    end else begin
      if (accept && (event_count != '1)) event_n = event_count + CNT_WIDTH'(1);
      if (drop   && (drop_count  != '1)) drop_n  = drop_count  + CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      req_d       <= 1'b0;
      rst_out     <= 1'b0;
      busy        <= 1'b0;
      req_ack     <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_n;
      timer_q     <= timer_n;
      req_d       <= req;
      // Outputs are registered from the next state so they line up with it.
      rst_out     <= (state_n == ASSERT);
      busy        <= (state_n != IDLE);
      req_ack     <= accept;
      event_count <= event_n;
      drop_count  <= drop_n;
    end
  end

endmodule

// File: tb/tb_force_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_force_reset_sequencer
//
// Table-driven check of force_reset_sequencer (STRETCH=4, COOLDOWN=3,
// CNT_WIDTH=4), plus a hand-written sequence on a second instance built with
// COOLDOWN_CYCLES=0. Each table row holds the inputs driven for one cycle and
// the outputs expected right after the following rising edge.
// -----------------------------------------------------------------------------
module tb_force_reset_sequencer;

  localparam int S = 4;
  localparam int C = 3;
  localparam int P = S + C + 1;   // accept-to-accept period for a held request

  logic       clk = 1'b0;
  logic       rst, frc, ext, clr;
  logic       ro, bz, ak;
  logic [3:0] ev, dr;

  logic       z_rst, z_frc, z_ext, z_clr;
  logic       z_ro, z_bz, z_ak;
  logic [3:0] z_ev, z_dr;

  always #5 clk = ~clk;

  force_reset_sequencer #(
    .STRETCH_CYCLES (S),
    .COOLDOWN_CYCLES(C),
    .CNT_WIDTH      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .force_reset (frc),
    .ext_rst_req (ext),
    .clear_counts(clr),
    .rst_out     (ro),
    .busy        (bz),
    .req_ack     (ak),
    .event_count (ev),
    .drop_count  (dr)
  );

  force_reset_sequencer #(
    .STRETCH_CYCLES (S),
    .COOLDOWN_CYCLES(0),
    .CNT_WIDTH      (4)
  ) dut_nocool (
    .clk         (clk),
    .rst         (z_rst),
    .force_reset (z_frc),
    .ext_rst_req (z_ext),
    .clear_counts(z_clr),
    .rst_out     (z_ro),
    .busy        (z_bz),
    .req_ack     (z_ak),
    .event_count (z_ev),
    .drop_count  (z_dr)
  );

  typedef struct {
    logic       rst, frc, ext, clr;
    logic       ro, bz, ak;
    logic [3:0] ev, dr;
  } vec_t;

  typedef struct {
    int         idx;
    logic       ro, bz, ak;
    logic [3:0] ev, dr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ev_m  = 0;
  int   dr_m  = 0;

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  // Appends one row; the counter expectations follow a tiny saturating model
  // (reset/clear zero them, an ack or a drop bumps them).
  task automatic add(input logic r, input logic f, input logic e, input logic c,
                     input logic o, input logic b, input logic a, input logic d);
    vec_t v;
    if (r || c) begin
      ev_m = 0;
      dr_m = 0;
    end else begin
      if (a && ev_m < 15) ev_m++;
      if (d && dr_m < 15) dr_m++;
    end
    v.rst = r; v.frc = f; v.ext = e; v.clr = c;
    v.ro = o;  v.bz = b;  v.ak = a;
    v.ev = 4'(ev_m);
    v.dr = 4'(dr_m);
    vecs.push_back(v);
  endtask

  initial begin
    exp_t x;
    rst = 1'b0; frc = 1'b0; ext = 1'b0; clr = 1'b0;
    z_rst = 1'b1; z_frc = 1'b0; z_ext = 1'b0; z_clr = 1'b0;

    // Reset with a request present: reset wins, everything reads zero.
    add(1, 1, 1, 0, 0, 0, 0, 0);

    // Single-cycle pulse on the first cycle after reset release.
    for (int j = 0; j <= P; j++)
      add(0, j == 0, 0, 0, j < S, j < S + C, j == 0, 0);

    // ext pulse, then a force pulse three cycles later: one accept, one drop.
    add(0, 0, 0, 1, 0, 0, 0, 0);
    for (int j = 0; j <= P; j++)
      add(0, j == 3, j == 0, 0, j < S, j < S + C, j == 0, j == 3);

    // Both sources together count once; again during ASSERT is one drop;
    // a clear during ASSERT zeroes counters without touching rst_out.
    for (int j = 0; j <= P; j++)
      add(0, j == 0 || j == 2, j == 0 || j == 2, j == 3,
          j < S, j < S + C, j == 0, j == 2);

    // force_reset held: re-accepted every P cycles, no drops.
    for (int j = 0; j < 3 * P; j++)
      add(0, 1, 0, 0, (j % P) < S, (j % P) < S + C, (j % P) == 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset two cycles into ASSERT aborts; a later request is accepted.
    for (int j = 0; j < 5 + P; j++) begin
      if (j < 2)       add(0, j == 0, 0, 0, 1, 1, j == 0, 0);
      else if (j == 2) add(1, 0, 0, 0, 0, 0, 0, 0);
      else if (j < 5)  add(0, 0, 0, 0, 0, 0, 0, 0);
      else             add(0, j == 5, 0, 0, (j - 5) < S, (j - 5) < S + C, j == 5, 0);
    end

    // Twenty isolated requests saturate event_count at 15; the 21st comes
    // with clear_counts and leaves event_count at 0.
    add(0, 0, 0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 21; n++)
      for (int j = 0; j < 10; j++)
        add(0, j == 0, 0, n == 20 && j == 0, j < S, j < S + C, j == 0, 0);

    // Apply the table through the scoreboard.
    foreach (vecs[i]) begin
      rst = vecs[i].rst; frc = vecs[i].frc; ext = vecs[i].ext; clr = vecs[i].clr;
      x.idx = i; x.ro = vecs[i].ro; x.bz = vecs[i].bz; x.ak = vecs[i].ak;
      x.ev = vecs[i].ev; x.dr = vecs[i].dr;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check("rst_out",     x.idx, 8'(ro), 8'(x.ro));
      check("busy",        x.idx, 8'(bz), 8'(x.bz));
      check("req_ack",     x.idx, 8'(ak), 8'(x.ak));
      check("event_count", x.idx, 8'(ev), 8'(x.ev));
      check("drop_count",  x.idx, 8'(dr), 8'(x.dr));
    end
    rst = 1'b0; frc = 1'b0; ext = 1'b0; clr = 1'b0;

    // Zero-cooldown build: pulse of S cycles, one idle cycle, then a held
    // request is accepted again.
    @(posedge clk);
    #1;
    check("nocool reset rst_out", 0, 8'(z_ro), 8'd0);
    check("nocool reset busy",    0, 8'(z_bz), 8'd0);
    check("nocool reset events",  0, 8'(z_ev), 8'd0);
    z_rst = 1'b0;
    z_frc = 1'b1;
    for (int k = 0; k <= 2 * (S + 1); k++) begin
      @(posedge clk);
      #1;
      check("nocool rst_out", k, 8'(z_ro), 8'((k % (S + 1)) < S));
      check("nocool busy",    k, 8'(z_bz), 8'((k % (S + 1)) < S));
      check("nocool req_ack", k, 8'(z_ak), 8'((k % (S + 1)) == 0));
      check("nocool events",  k, 8'(z_ev), 8'(k / (S + 1) + 1));
      check("nocool drops",   k, 8'(z_dr), 8'd0);
    end
    z_frc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
